// File: rtl/ps2_keycaps.sv
// PS/2 set-2 keyboard receiver that decodes make/break codes into a held-key matrix bus.
// keycaps bit index is row*5+col; bit 15 is the OR of both shift keys.
module ps2_keycaps #(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [39:0] keycaps,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam int unsigned FiltW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_f;
  logic [FiltW-1:0] r_filt_cnt;
  logic             w_fall;

  state_e           r_state, w_state_d;
  logic [2:0]       r_bit_cnt, w_bit_cnt_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_par, w_par_d;
  logic [ToW-1:0]   r_to_cnt, w_to_cnt_d;
  logic             w_good, w_err;

  logic [7:0]       r_rx_byte;
  logic             r_rx_valid, r_frame_err;

  logic [39:0]      r_keys, w_keys_d;
  logic             r_ext, w_ext_d, r_brk, w_brk_d;
  logic             r_lsh, w_lsh_d, r_rsh, w_rsh_d;
  logic [6:0]       w_hit;

  // Line idles high, so the synchronizers and filter reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_f    <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_clk_f) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltW'(FILT - 1)) begin
        r_clk_f    <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_f & ~r_clk_s2 & (r_filt_cnt == FiltW'(FILT - 1));

  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_par_d     = r_par;
    w_to_cnt_d  = r_to_cnt;
    w_good      = 1'b0;
    w_err       = 1'b0;
    if (r_state != StIdle) w_to_cnt_d = r_to_cnt + 1'b1;
    if (w_fall) begin
      w_to_cnt_d = '0;
      case (r_state)
        StIdle: begin
          if (!r_dat_s2) begin
            w_state_d   = StData;
            w_bit_cnt_d = 3'd0;
            w_par_d     = 1'b0;
          end
        end
        StData: begin
          w_shift_d   = {r_dat_s2, r_shift[7:1]};
          w_par_d     = r_par ^ r_dat_s2;
          w_bit_cnt_d = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_d = StParity;
        end
        StParity: begin
          w_par_d   = r_par ^ r_dat_s2;
          w_state_d = StStop;
        end
        StStop: begin
          w_state_d = StIdle;
          if (r_dat_s2 && r_par) w_good = 1'b1;
          else                   w_err  = 1'b1;
        end
        default: w_state_d = StIdle;
      endcase
    end else if (r_state != StIdle && r_to_cnt == ToW'(TIMEOUT - 1)) begin
      w_state_d  = StIdle;
      w_to_cnt_d = '0;
      w_err      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_par       <= w_par_d;
      r_to_cnt    <= w_to_cnt_d;
      r_rx_valid  <= w_good;
      r_frame_err <= w_err;
      if (w_good) r_rx_byte <= r_shift;
    end
  end

  // Returns {hit, bit index}; shift codes are handled separately.
  function automatic logic [6:0] lookup(input logic [7:0] code);
    case (code)
      8'h16: lookup = {1'b1, 6'd0};   8'h1E: lookup = {1'b1, 6'd1};
      8'h26: lookup = {1'b1, 6'd2};   8'h25: lookup = {1'b1, 6'd3};
      8'h2E: lookup = {1'b1, 6'd4};   8'h15: lookup = {1'b1, 6'd5};
      8'h1D: lookup = {1'b1, 6'd6};   8'h24: lookup = {1'b1, 6'd7};
      8'h2D: lookup = {1'b1, 6'd8};   8'h2C: lookup = {1'b1, 6'd9};
      8'h1C: lookup = {1'b1, 6'd10};  8'h1B: lookup = {1'b1, 6'd11};
      8'h23: lookup = {1'b1, 6'd12};  8'h2B: lookup = {1'b1, 6'd13};
      8'h34: lookup = {1'b1, 6'd14};  8'h1A: lookup = {1'b1, 6'd16};
      8'h22: lookup = {1'b1, 6'd17};  8'h21: lookup = {1'b1, 6'd18};
      8'h2A: lookup = {1'b1, 6'd19};  8'h29: lookup = {1'b1, 6'd20};
      8'h41: lookup = {1'b1, 6'd21};  8'h3A: lookup = {1'b1, 6'd22};
      8'h31: lookup = {1'b1, 6'd23};  8'h32: lookup = {1'b1, 6'd24};
      8'h5A: lookup = {1'b1, 6'd25};  8'h4B: lookup = {1'b1, 6'd26};
      8'h42: lookup = {1'b1, 6'd27};  8'h3B: lookup = {1'b1, 6'd28};
      8'h33: lookup = {1'b1, 6'd29};  8'h4D: lookup = {1'b1, 6'd30};
      8'h44: lookup = {1'b1, 6'd31};  8'h43: lookup = {1'b1, 6'd32};
      8'h3C: lookup = {1'b1, 6'd33};  8'h35: lookup = {1'b1, 6'd34};
      8'h45: lookup = {1'b1, 6'd35};  8'h46: lookup = {1'b1, 6'd36};
      8'h3E: lookup = {1'b1, 6'd37};  8'h3D: lookup = {1'b1, 6'd38};
      8'h36: lookup = {1'b1, 6'd39};
      default: lookup = 7'd0;
    endcase
  endfunction

  assign w_hit = lookup(r_rx_byte);

  always_comb begin
    w_keys_d = r_keys;
    w_ext_d  = r_ext;
    w_brk_d  = r_brk;
    w_lsh_d  = r_lsh;
    w_rsh_d  = r_rsh;
    if (r_rx_valid) begin
      case (r_rx_byte)
        8'hE0: w_ext_d = 1'b1;
        8'hF0: w_brk_d = 1'b1;
        8'h00, 8'hFF: begin
          w_keys_d = '0;
          w_ext_d  = 1'b0;
          w_brk_d  = 1'b0;
          w_lsh_d  = 1'b0;
          w_rsh_d  = 1'b0;
        end
        default: begin
          w_ext_d = 1'b0;
          w_brk_d = 1'b0;
          if (r_ext) begin
            if (r_rx_byte == 8'h5A) w_keys_d[25] = ~r_brk;
          end else if (r_rx_byte == 8'h12) begin
            w_lsh_d = ~r_brk;
          end else if (r_rx_byte == 8'h59) begin
            w_rsh_d = ~r_brk;
          end else if (w_hit[6]) begin
            w_keys_d[w_hit[5:0]] = ~r_brk;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_lsh  <= 1'b0;
      r_rsh  <= 1'b0;
    end else begin
      r_keys <= w_keys_d;
      r_ext  <= w_ext_d;
      r_brk  <= w_brk_d;
      r_lsh  <= w_lsh_d;
      r_rsh  <= w_rsh_d;
    end
  end

  always_comb begin
    keycaps     = r_keys;
    keycaps[15] = r_lsh | r_rsh;
  end

  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keycaps.sv
// Scoreboard bench for ps2_keycaps: frames are driven on the PS/2 lines, a key-state
// model predicts each rx_valid/frame_err event and the keycaps bus that follows it.
module tb_ps2_keycaps;

  localparam int unsigned FILT    = 8;
  localparam int unsigned TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [39:0] keycaps;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  always #5 clk = ~clk;

  ps2_keycaps #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .keycaps   (keycaps),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic        is_err;
    logic [7:0]  b;
    logic [39:0] keys;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Key code for each matrix position; position 15 is left shift (right shift is 0x59).
  logic [7:0] codes_by_bit [40] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h29, 8'h41, 8'h3A, 8'h31, 8'h32, 8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35, 8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36};
  int code_map [int];

  bit m_keys [40];
  bit m_ls, m_rs, m_ext, m_brk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [39:0] m_caps();
    logic [39:0] v;
    for (int i = 0; i < 40; i++) v[i] = m_keys[i];
    v[15] = m_ls | m_rs;
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 40; i++) m_keys[i] = 1'b0;
    m_ls = 0; m_rs = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) m_reset();
    else begin
      if (m_ext) begin
        if (b == 8'h5A) m_keys[25] = !m_brk;
      end else if (b == 8'h12) m_ls = !m_brk;
      else if (b == 8'h59) m_rs = !m_brk;
      else if (code_map.exists(int'(b))) m_keys[code_map[int'(b)]] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Bits go out LSB first: start, 8 data, parity, stop; data changes while ps2_clk is high.
  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      #100;
      ps2_clk = 1'b0;
      #200;
      ps2_clk = 1'b1;
      #100;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    exp_t e;
    logic [10:0] fb;
    if (bad_par || bad_stop) begin
      e = '{is_err: 1'b1, b: 8'h00, keys: m_caps()};
    end else begin
      m_byte(b);
      e = '{is_err: 1'b0, b: b, keys: m_caps()};
    end
    exp_q.push_back(e);
    fb = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    ps2_bits(fb, 11);
    #500;
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b0, 1'b0);
  endtask

  // Monitor: every output event must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: rx_valid=%b frame_err=%b, required none",
                   rx_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", {39'b0, frame_err}, {39'b0, e.is_err});
          check("event_kind_valid", {39'b0, rx_valid}, {39'b0, ~e.is_err});
          if (!e.is_err) check("rx_byte", {32'b0, rx_byte}, {32'b0, e.b});
          @(negedge clk);
          check("keycaps", keycaps, e.keys);
          check("one_cycle_pulse", {39'b0, rx_valid | frame_err}, 40'b0);
        end
      end
    end
  end

  initial begin
    logic [10:0] fb;
    int r;
    logic [7:0] b;

    for (int i = 0; i < 40; i++) if (i != 15) code_map[int'(codes_by_bit[i])] = i;
    m_reset();

    repeat (3) @(negedge clk);
    check("reset_keycaps", keycaps, 40'b0);
    check("reset_rx_byte", {32'b0, rx_byte}, 40'b0);
    check("reset_rx_valid", {39'b0, rx_valid}, 40'b0);
    check("reset_frame_err", {39'b0, frame_err}, 40'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    good(8'h1C); good(8'hF0); good(8'h1C);
    good(8'h12); good(8'h59); good(8'hF0); good(8'h12);
    good(8'hF0); good(8'h59);
    send(8'h29, 1'b1, 1'b0);

    // Partial frame: start + 4 data bits, then the clock stops.
    exp_q.push_back('{is_err: 1'b1, b: 8'h00, keys: m_caps()});
    fb = {1'b1, ~^8'h55, 8'h55, 1'b0};
    ps2_bits(fb, 5);
    repeat (TIMEOUT + 100) @(negedge clk);
    good(8'h16);

    good(8'hE0); good(8'h5A);
    good(8'hE0); good(8'hF0); good(8'h5A);
    good(8'hE0); good(8'h75);
    good(8'h16); good(8'h45); good(8'hFF);
    send(8'h1C, 1'b0, 1'b1);
    good(8'hAA); good(8'hFA); good(8'hEE);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       send(8'($urandom), 1'b1, 1'b0);
      else if (r < 12) send(8'($urandom), 1'b0, 1'b1);
      else if (r < 28) good(8'hF0);
      else if (r < 36) good(8'hE0);
      else if (r < 39) good(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      else if (r < 48) good(8'($urandom));
      else if (r < 54) good(8'h59);
      else begin
        b = codes_by_bit[$urandom_range(0, 39)];
        good(b);
      end
    end

    // Reset in the middle of a frame while keys are held.
    good(8'h16); good(8'h2C);
    fb = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
    ps2_bits(fb, 6);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_keycaps", keycaps, 40'b0);
    check("midreset_rx_byte", {32'b0, rx_byte}, 40'b0);
    check("midreset_rx_valid", {39'b0, rx_valid}, 40'b0);
    check("midreset_frame_err", {39'b0, frame_err}, 40'b0);
    m_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    good(8'h16);

    repeat (100) @(negedge clk);
    check("all_events_seen", 40'(exp_q.size()), 40'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keycaps.md
PS2_KEYCAPS -- requirements
Module: ps2_keycaps

Interface
REQ-001 SHALL have parameter FILT, default 8, meaning the number of consecutive stable clk cycles required to accept a new ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the maximum clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1, system clock; the block has one clock.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port ps2_clk, input, 1, PS/2 clock line (asynchronous).
REQ-006 SHALL have port ps2_dat, input, 1, PS/2 data line (asynchronous).
REQ-007 SHALL have port keycaps, output, 40, 1 = key held; bit = row*5+col, the matrix bus consumed by the keyboard/tape buffer.
REQ-008 SHALL have port rx_byte, output, 8, last valid received byte.
REQ-009 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_byte is updated.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchronizer, then filter ps2_clk so its level changes only after FILT equal samples.
REQ-012 SHALL sample the synchronized ps2_dat on each falling edge of the filtered ps2_clk.
REQ-013 SHALL run the receiver FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
- A start bit of 1 in IDLE is ignored and the FSM stays in IDLE.
REQ-014 SHALL require odd parity over data+parity bits and a stop bit of 1.
- On failure: pulse frame_err, discard the byte, leave decoder flags and keycaps unchanged.
REQ-015 SHALL return from any non-IDLE state to IDLE, pulsing frame_err once, if TIMEOUT cycles pass without a falling edge.
- The partial byte is discarded.
REQ-016 SHALL, on a good stop bit, update rx_byte and pulse rx_valid in the next cycle.
- keycaps reflects that byte from the cycle after rx_valid.
REQ-017 SHALL run the decoder on each valid byte:
- 0xE0 sets ext.
- 0xF0 sets brk.
- 0x00 or 0xFF clears all keycaps and both flags.
- Any other byte is looked up, then ext and brk are cleared.
REQ-018 SHALL, for a mapped code, clear its keycaps bit if brk=1, else set it.
- Unmapped codes (including 0xAA, 0xFA, 0xEE) change nothing except clearing the flags.
REQ-019 SHALL, when ext=1, map only 0x5A (to bit 25) and ignore every other code.
REQ-020 SHALL use this set-2 map, code:bit:
- 16:0, 1E:1, 26:2, 25:3, 2E:4
- 15:5, 1D:6, 24:7, 2D:8, 2C:9
- 1C:10, 1B:11, 23:12, 2B:13, 34:14
- 12 and 59:15, 1A:16, 22:17, 21:18, 2A:19
- 29:20, 41:21, 3A:22, 31:23, 32:24
- 5A:25, 4B:26, 42:27, 3B:28, 33:29
- 4D:30, 44:31, 43:32, 3C:33, 35:34
- 45:35, 46:36, 3E:37, 3D:38, 36:39
REQ-021 SHALL drive bit 15 from an OR of separate left-shift and right-shift held flags, so releasing one shift key keeps bit 15 set while the other is held.
REQ-022 SHALL never set more than one keycaps bit per byte, and repeated make codes for a held key leave keycaps unchanged.

Reset
REQ-023 SHALL, while rst_n=0, force keycaps=0, rx_byte=0x00, rx_valid=0, frame_err=0, FSM=IDLE, ext=0, brk=0, both shift flags=0, and clear the filter and timeout counters.
REQ-024 SHALL, on rst_n assertion mid-frame, abandon the frame and, after release, wait for a fresh start bit.

Verification
REQ-025 SHALL be verified by sending frame 0x1C (parity 0) -> rx_valid pulse, rx_byte=0x1C, keycaps=bit10 only; then F0,1C -> keycaps=0.
REQ-026 SHALL be verified by sending 12, 59, F0 12 -> bit15 still 1; then F0 59 -> bit15 = 0.
REQ-027 SHALL be verified by sending 0x29 with wrong parity -> frame_err pulse, no rx_valid, keycaps unchanged.
REQ-028 SHALL be verified by stopping ps2_clk after 4 data bits -> after TIMEOUT cycles one frame_err pulse, FSM IDLE, and the next good frame 0x16 sets bit0.
REQ-029 SHALL be verified by sending E0 5A -> bit25 set; E0 F0 5A -> cleared; E0 75 -> no change.
REQ-030 SHALL be verified by holding keys 16 and 45, then sending 0xFF -> keycaps=0; and by asserting rst_n=0 mid-frame -> all outputs at reset values, with the following full frame decoded correctly.
